// File: rtl/green_pkg.sv
// Shared definitions for the green datapath execute unit: opcodes, FSM
// state encoding and the instruction field-width helper.
// Optional feature macro: GREEN_DEC_EN (enables the DEC opcode).
package green_pkg;

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_BR  = 4'b0011;
    localparam logic [3:0] OP_DEC = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Address/target field width: what is left below opcode and register select.
    function automatic int addr_width(input int data_w, input int rsel_w);
        return data_w - 4 - rsel_w;
    endfunction

endpackage

// File: rtl/green_regfile.sv
// NREG x DATA_W register file: one synchronous write port, two
// combinational read ports (operand and debug), synchronous reset to zero.
module green_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [$clog2(NREG)-1:0]   wsel,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [$clog2(NREG)-1:0]   rsel,
    output logic [DATA_W-1:0]         rdata,
    input  logic [$clog2(NREG)-1:0]   dbg_sel,
    output logic [DATA_W-1:0]         dbg_data
);

    logic [DATA_W-1:0] regs [NREG];

    // Register array update: clear on reset, single write port otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wsel] <= wdata;
        end
    end

    assign rdata    = regs[rsel];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/green_exec_unit.sv
// Instruction decode/execute unit: accepts one instruction per handshake in
// IDLE, executes it in a single EXEC cycle, and for loads waits in WAIT for
// read data under a timeout. Optional macro GREEN_DEC_EN adds the DEC opcode.
module green_exec_unit
    import green_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NREG     = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ins_valid,
    output logic                                   ins_ready,
    input  logic [DATA_W-1:0]                      ins,
    input  logic                                   branch,
    output logic                                   mem_req,
    output logic                                   mem_we,
    output logic [DATA_W-5-$clog2(NREG):0]         mem_addr,
    output logic [DATA_W-1:0]                      mem_wdata,
    input  logic                                   mem_rvalid,
    input  logic [DATA_W-1:0]                      mem_rdata,
    output logic                                   br_taken,
    output logic [DATA_W-5-$clog2(NREG):0]         br_target,
    output logic                                   err,
    input  logic                                   err_clr,
    input  logic [$clog2(NREG)-1:0]                dbg_sel,
    output logic [DATA_W-1:0]                      dbg_data
);

    localparam int RSEL_W = $clog2(NREG);
    localparam int ADDR_W = addr_width(DATA_W, RSEL_W);
    localparam int CNT_W  = $clog2(WAIT_MAX + 1);

    state_t              state, state_n;
    logic [DATA_W-1:0]   ins_q;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          op;
    logic [RSEL_W-1:0]   sel;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   operand;
    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;
    logic                timeout;
    logic                accept;

    // All decode works from the latched word, never from the live ins port.
    assign op   = ins_q[DATA_W-1 -: 4];
    assign sel  = ins_q[DATA_W-5 -: RSEL_W];
    assign addr = ins_q[ADDR_W-1:0];

    assign ins_ready = (state == S_IDLE);
    assign accept    = ins_valid && ins_ready;
    assign mem_addr  = addr;
    assign br_target = addr;
    assign mem_wdata = operand;

    green_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .wsel     (sel),
        .wdata    (rf_wdata),
        .rsel     (sel),
        .rdata    (operand),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state, strobes and register-file write decode.
    always_comb begin
        state_n  = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        br_taken = 1'b0;
        rf_we    = 1'b0;
        rf_wdata = mem_rdata;
        timeout  = 1'b0;
        case (state)
            S_IDLE: if (accept) state_n = S_EXEC;
            S_EXEC: begin
                state_n = S_IDLE;
                case (op)
                    OP_LD: begin
                        mem_req = 1'b1;
                        state_n = S_WAIT;
                    end
                    OP_ST: begin
                        mem_req = 1'b1;
                        mem_we  = 1'b1;
                    end
                    OP_INC: begin
                        rf_we    = 1'b1;
                        rf_wdata = operand + DATA_W'(1);
                    end
                    OP_BR: br_taken = branch;
`ifdef GREEN_DEC_EN
                    OP_DEC: begin
                        rf_we    = 1'b1;
                        rf_wdata = operand - DATA_W'(1);
                    end
`endif
                    default: ;
                endcase
            end
            S_WAIT: begin
                // Data arriving on the final counted cycle still wins over timeout.
                if (mem_rvalid) begin
                    rf_we   = 1'b1;
                    state_n = S_IDLE;
                end else if (cnt == CNT_W'(WAIT_MAX - 1)) begin
                    timeout = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Instruction latch, loaded only on a handshake.
    always_ff @(posedge clk) begin
        if (rst)         ins_q <= '0;
        else if (accept) ins_q <= ins;
    end

    // Load wait counter: cleared in EXEC, counts idle WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst)                                cnt <= '0;
        else if (state == S_EXEC)               cnt <= '0;
        else if (state == S_WAIT && !mem_rvalid) cnt <= cnt + CNT_W'(1);
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)          err <= 1'b0;
        else if (timeout) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

endmodule

// File: tb/tb_green_exec_unit.sv
// Directed bench for green_exec_unit (DATA_W=16, NREG=4, WAIT_MAX=15).
module tb_green_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins;
    logic        branch;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        br_taken;
    logic [9:0]  br_target;
    logic        err;
    logic        err_clr;
    logic [1:0]  dbg_sel;
    logic [15:0] dbg_data;

    int n_assert = 0;
    int n_fail   = 0;

    green_exec_unit #(.DATA_W(16), .NREG(4), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins(ins), .branch(branch), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .br_taken(br_taken), .br_target(br_target),
        .err(err), .err_clr(err_clr), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] sel,
                                       input logic [9:0] addr);
        return {op, sel, addr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [15:0] exp);
        dbg_sel = sel;
        #1;
        check(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    // Full load with data returned on the first WAIT cycle.
    task automatic do_ld(input logic [1:0] sel, input logic [15:0] data);
        ins_valid = 1'b1; ins = mk(4'b0000, sel, 10'h0);
        step();
        ins_valid = 1'b0;
        step();
        mem_rvalid = 1'b1; mem_rdata = data;
        step();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int acc;
        rst = 1'b1; ins_valid = 1'b0; ins = '0; branch = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0; err_clr = 1'b0; dbg_sel = '0;
        step(); step();
        rst = 1'b0;

        // 1: reset state
        check("rst_ready", ins_ready, 1);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_br", br_taken, 0);
        check("rst_err", err, 0);
        chk_reg("rst_r0", 0, 16'h0);
        chk_reg("rst_r3", 3, 16'h0);

        // 1: LD R2,0x05A with data three cycles after the request
        ins_valid = 1'b1; ins = mk(4'b0000, 2'd2, 10'h05A);
        step();
        ins_valid = 1'b0;
        check("ld_req", mem_req, 1);
        check("ld_we", mem_we, 0);
        check("ld_addr", mem_addr, 10'h05A);
        check("ld_ready_exec", ins_ready, 0);
        step();
        check("ld_req_pulse", mem_req, 0);
        step(); step();
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        chk_reg("ld_prewrite", 2, 16'h0);
        step();
        mem_rvalid = 1'b0;
        check("ld_ready_after", ins_ready, 1);
        chk_reg("ld_r2", 2, 16'hBEEF);

        // 2: INC wraps, then ST of the wrapped value
        do_ld(2'd1, 16'hFFFF);
        chk_reg("r1_loaded", 1, 16'hFFFF);
        ins_valid = 1'b1; ins = mk(4'b0010, 2'd1, 10'h0);
        step();
        ins_valid = 1'b0;
        chk_reg("inc_prewrite", 1, 16'hFFFF);
        step();
        chk_reg("inc_wrap", 1, 16'h0000);
        ins_valid = 1'b1; ins = mk(4'b0001, 2'd1, 10'h3FF);
        step();
        ins_valid = 1'b0;
        check("st_req", mem_req, 1);
        check("st_we", mem_we, 1);
        check("st_wdata", mem_wdata, 16'h0000);
        check("st_addr", mem_addr, 10'h3FF);
        step();
        check("st_req_pulse", mem_req, 0);

        // 3: branch taken / not taken; stray rvalid in IDLE ignored
        ins_valid = 1'b1; ins = mk(4'b0011, 2'd0, 10'h123); branch = 1'b1;
        step();
        ins_valid = 1'b0;
        check("br_taken", br_taken, 1);
        check("br_target", br_target, 10'h123);
        step();
        branch = 1'b0;
        check("br_pulse", br_taken, 0);
        check("br_ready", ins_ready, 1);
        ins_valid = 1'b1; ins = mk(4'b0011, 2'd0, 10'h123);
        step();
        ins_valid = 1'b0;
        check("br_not_taken", br_taken, 0);
        step();
        check("br_nt_ready", ins_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = 16'h7777;
        step();
        mem_rvalid = 1'b0;
        chk_reg("idle_rvalid_r2", 2, 16'hBEEF);
        chk_reg("idle_rvalid_r0", 0, 16'h0);

        // 4: load timeout after 15 WAIT cycles, R3 preserved
        do_ld(2'd3, 16'h1234);
        ins_valid = 1'b1; ins = mk(4'b0000, 2'd3, 10'h001);
        step();
        ins_valid = 1'b0;
        step();
        repeat (14) step();
        check("to_err_before", err, 0);
        check("to_ready_before", ins_ready, 0);
        step();
        check("to_err", err, 1);
        check("to_ready", ins_ready, 1);
        chk_reg("to_r3", 3, 16'h1234);
        // second timeout with err_clr on the same cycle: set wins
        ins_valid = 1'b1; ins = mk(4'b0000, 2'd3, 10'h002);
        step();
        ins_valid = 1'b0;
        step();
        repeat (14) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("to_set_wins", err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_clr", err, 0);
        // rvalid on the final counted cycle wins over timeout
        ins_valid = 1'b1; ins = mk(4'b0000, 2'd0, 10'h003);
        step();
        ins_valid = 1'b0;
        step();
        repeat (14) step();
        mem_rvalid = 1'b1; mem_rdata = 16'h5555;
        step();
        mem_rvalid = 1'b0;
        check("last_rvalid_err", err, 0);
        chk_reg("last_rvalid_r0", 0, 16'h5555);

        // 5: reset during WAIT, late rvalid ignored
        ins_valid = 1'b1; ins = mk(4'b0000, 2'd2, 10'h010);
        step();
        ins_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hAAAA;
        step();
        mem_rvalid = 1'b0;
        check("rstw_ready", ins_ready, 1);
        chk_reg("rstw_r0", 0, 16'h0);
        chk_reg("rstw_r1", 1, 16'h0);
        chk_reg("rstw_r2", 2, 16'h0);
        chk_reg("rstw_r3", 3, 16'h0);

        // 6: opcode 0100 on R0
        ins_valid = 1'b1; ins = mk(4'b0100, 2'd0, 10'h0);
        step();
        ins_valid = 1'b0;
        step();
`ifdef GREEN_DEC_EN
        chk_reg("dec_r0", 0, 16'hFFFF);
`else
        chk_reg("dec_r0", 0, 16'h0000);
`endif
        // back-to-back INC R1 with ins_valid held high
        acc = 0;
        ins_valid = 1'b1; ins = mk(4'b0010, 2'd1, 10'h0);
        for (int i = 0; i < 8; i++) begin
            if (ins_ready) acc++;
            step();
        end
        ins_valid = 1'b0;
        check("b2b_accepts", acc, 4);
        chk_reg("b2b_r1", 1, 16'h0004);
        check("b2b_ready", ins_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
